// File: rtl/riscblade_pkg.sv
// Shared widths, arbiter state encoding and winner codes for the memory port arbiter.
package riscblade_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IF_ACC = 2'd1,
    DM_ACC = 2'd2
  } arb_state_e;

  localparam logic WIN_IF = 1'b0;
  localparam logic WIN_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN selects alternating priority on conflict; otherwise DM has fixed priority.
module mem_arb_pick
  import riscblade_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_win,
  output logic winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = WIN_DM;
    if (if_req && dm_req) begin
      winner = (last_win == WIN_DM) ? WIN_IF : WIN_DM;
    end else if (if_req) begin
      winner = WIN_IF;
    end
  end
`else
  logic unused_last_win;
  assign unused_last_win = last_win;

  always_comb begin
    winner = WIN_DM;
    if (if_req && !dm_req) begin
      winner = WIN_IF;
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// MEM_ARB_RR_EN enables alternating priority on conflict (last-winner flag kept).
module mem_port_arbiter
  import riscblade_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              memwrite,
  input  logic [DATA_W-1:0] mem_out,
  output logic              pc_en,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_rvalid_q, dm_rvalid_q;
  logic              if_req_m, dm_req_m, grant_load;
  logic              winner, last_win;

  // The requester being served still holds REQ high, so ignore it for this cycle.
  assign if_req_m   = if_req && (state_q != IF_ACC);
  assign dm_req_m   = dm_req && (state_q != DM_ACC);
  assign grant_load = if_req_m || dm_req_m;

  mem_arb_pick u_pick (
    .if_req   (if_req_m),
    .dm_req   (dm_req_m),
    .last_win (last_win),
    .winner   (winner)
  );

`ifdef MEM_ARB_RR_EN
  logic last_win_q;

  always_ff @(posedge clock) begin
    if (rst) begin
      last_win_q <= WIN_DM;
    end else if (grant_load) begin
      last_win_q <= winner;
    end
  end

  assign last_win = last_win_q;
`else
  assign last_win = WIN_DM;
`endif

  always_comb begin
    state_d = IDLE;
    if (grant_load) begin
      state_d = (winner == WIN_DM) ? DM_ACC : IF_ACC;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_load) begin
        if (winner == WIN_DM) begin
          addr_q  <= dm_addr;
          wdata_q <= dm_wdata;
          we_q    <= dm_we;
        end else begin
          addr_q  <= if_addr;
          we_q    <= 1'b0;
        end
      end
      if_rvalid_q <= (state_q == IF_ACC);
      dm_rvalid_q <= (state_q == DM_ACC) && !we_q;
      if (state_q == IF_ACC) begin
        if_rdata_q <= mem_out;
      end
      if ((state_q == DM_ACC) && !we_q) begin
        dm_rdata_q <= mem_out;
      end
    end
  end

  // Grants and the write strobe drop immediately under reset to abort the access.
  assign if_gnt    = (state_q == IF_ACC) && !rst;
  assign dm_gnt    = (state_q == DM_ACC) && !rst;
  assign memwrite  = (state_q == DM_ACC) && we_q && !rst;
  assign pc_en     = if_gnt;
  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_data  = wdata_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, fetch, store, conflict, abort and fetch stream.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we;
  logic [15:0] if_addr, dm_addr, dm_wdata, mem_out;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, memwrite, pc_en, busy;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_data;

  int total = 0;
  int bad   = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  always #5 clock = ~clock;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clock     (clock),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .memwrite  (memwrite),
    .mem_out   (mem_out),
    .pc_en     (pc_en),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic exp_dm;

  initial begin
    rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 16'h0000; dm_addr = 16'h0200; dm_wdata = 16'h0000; mem_out = 16'h5555;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_dm_gnt", dm_gnt, 0);
    chk("rst_memwrite", memwrite, 0);
    chk("rst_pc_en", pc_en, 0);
    chk("rst_rvalid", {if_rvalid, dm_rvalid}, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    chk("rst_mem_bus", {mem_addr, mem_data}, 0);

    // release with both requests high
    rst = 1'b0;
    tick();
    exp_dm = !RR;
    chk("rel_dm_gnt", dm_gnt, exp_dm);
    chk("rel_if_gnt", if_gnt, !exp_dm);
    chk("rel_busy", busy, 1);
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    chk("rel_idle", busy, 0);
    tick();

    // fetch
    if_req = 1'b1; if_addr = 16'h0004; mem_out = 16'hA123;
    tick();
    chk("fetch_gnt", if_gnt, 1);
    chk("fetch_pc_en", pc_en, 1);
    chk("fetch_addr", mem_addr, 16'h0004);
    chk("fetch_memwrite", memwrite, 0);
    chk("fetch_rvalid_early", if_rvalid, 0);
    if_req = 1'b0;
    tick();
    chk("fetch_rvalid", if_rvalid, 1);
    chk("fetch_rdata", if_rdata, 16'hA123);
    chk("fetch_gnt_drop", {if_gnt, pc_en}, 0);
    mem_out = 16'h0BAD;
    tick();
    chk("fetch_rvalid_pulse", if_rvalid, 0);
    chk("fetch_rdata_hold", if_rdata, 16'hA123);

    // store
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'hBEEF;
    tick();
    chk("store_memwrite", memwrite, 1);
    chk("store_addr", mem_addr, 16'h0100);
    chk("store_data", mem_data, 16'hBEEF);
    chk("store_gnt", dm_gnt, 1);
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
    chk("store_no_rvalid", dm_rvalid, 0);
    chk("store_memwrite_drop", memwrite, 0);
    chk("store_dm_rdata_hold", dm_rdata, RR ? 16'h0000 : 16'h5555);
    tick();
    chk("store_no_rvalid2", dm_rvalid, 0);

    // conflict: both held for 4 grants, alternating with no bubble
    if_req = 1'b1; dm_req = 1'b1; if_addr = 16'h0008; dm_addr = 16'h0300;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_dm = ((i % 2) == 0) ? !RR : RR;
      chk($sformatf("conf_dm_gnt%0d", i), dm_gnt, exp_dm);
      chk($sformatf("conf_if_gnt%0d", i), if_gnt, !exp_dm);
      chk($sformatf("conf_addr%0d", i), mem_addr, exp_dm ? 16'h0300 : 16'h0008);
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    chk("conf_idle", busy, 0);
    tick();

    // abort a load with reset during DM_ACC
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0400; mem_out = 16'h7777;
    tick();
    chk("abort_gnt", dm_gnt, 1);
    rst = 1'b1; dm_req = 1'b0;
    #1;
    chk("abort_gnt_masked", dm_gnt, 0);
    tick();
    rst = 1'b0;
    chk("abort_idle", busy, 0);
    chk("abort_no_rvalid", dm_rvalid, 0);
    tick();
    chk("abort_no_rvalid2", dm_rvalid, 0);

    // reset during a write access kills the strobe in that cycle
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0500; dm_wdata = 16'h1234;
    tick();
    chk("wabort_memwrite", memwrite, 1);
    rst = 1'b1; dm_req = 1'b0; dm_we = 1'b0;
    #1;
    chk("wabort_memwrite_kill", memwrite, 0);
    tick();
    rst = 1'b0;
    chk("wabort_idle", busy, 0);

    // same-requester stream: idle cycle between fetches
    if_req = 1'b1; if_addr = 16'h0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stream_gnt%0d", i), if_gnt, ((i % 2) == 0) ? 1'b1 : 1'b0);
      chk($sformatf("stream_pc_en%0d", i), pc_en, ((i % 2) == 0) ? 1'b1 : 1'b0);
    end
    if_req = 1'b0;
    tick();
    tick();
    chk("stream_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, SHALL set the address width of all address ports.
REQ-002 Parameter DATA_W, default 16, SHALL set the data width of all data ports.
REQ-003 CLOCK  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 RST  in  1  SHALL be the reset, synchronous and active-high.
REQ-005 IF_REQ  in  1  SHALL carry the fetch read request, held high until IF_GNT.
REQ-006 IF_ADDR  in  ADDR_W  SHALL carry the fetch address (PC_OUT).
REQ-007 IF_GNT  out  1  SHALL pulse in the cycle the fetch accesses memory.
REQ-008 IF_RVALID / IF_RDATA  out  1 / DATA_W  SHALL carry the fetched instruction.
REQ-009 DM_REQ, DM_WE  in  1 each  SHALL carry the data request and its write flag.
REQ-010 DM_ADDR / DM_WDATA  in  ADDR_W / DATA_W  SHALL carry the data address and store data.
REQ-011 DM_GNT, DM_RVALID / DM_RDATA  out  1, 1 / DATA_W  SHALL mirror the IF group for the data port.
REQ-012 MEM_ADDR, MEM_DATA, MEMWRITE  out  ADDR_W, DATA_W, 1  SHALL drive the single-port MEMORY.
REQ-013 MEM_OUT  in  DATA_W  SHALL carry MEMORY read data, valid combinationally in the same cycle as MEM_ADDR.
REQ-014 PC_EN  out  1  SHALL enable the ProgramCounter.
REQ-015 BUSY  out  1  SHALL be high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, IF_ACC and DM_ACC.
REQ-017 IDLE: with no request pending, the FSM SHALL stay in IDLE.
REQ-018 IDLE: with a request pending, the FSM SHALL move to the winner's ACC state and register its ADDR/WDATA/WE at that edge.
REQ-019 ACC state: memory SHALL be driven from the registered values, the winner's GNT SHALL be high for exactly one cycle, and MEMWRITE SHALL equal the registered WE (IF always 0).
REQ-020 A read SHALL register MEM_OUT into RDATA at the end of the ACC cycle and assert RVALID for one cycle in the following cycle.
REQ-021 RDATA SHALL hold its value until the next read on that port.
REQ-022 A DM write SHALL never assert DM_RVALID.
REQ-023 Latency SHALL be REQ sampled at edge N, GNT in cycle N+1, RVALID in cycle N+2.
REQ-024 In an ACC cycle, the granted requester's REQ SHALL be masked, because it still reflects the request being served.
REQ-025 In an ACC cycle, if the other requester's REQ is high, the FSM SHALL go directly to that requester's ACC state with no bubble; otherwise it SHALL return to IDLE.
REQ-026 Back-to-back requests from the same requester SHALL incur one IDLE cycle.
REQ-027 When both requests are pending in IDLE (default build), DM SHALL win.
REQ-028 PC_EN SHALL equal IF_GNT, so the PC advances once per completed fetch.
REQ-029 Address arithmetic SHALL NOT be performed; addresses SHALL pass through unmodified at full width.

Reset
REQ-030 With RST high at a rising edge, the next state SHALL be IDLE.
REQ-031 With RST high at a rising edge, all GNT, RVALID, MEMWRITE, PC_EN and BUSY outputs SHALL be 0.
REQ-032 With RST high at a rising edge, RDATA, MEM_ADDR and MEM_DATA SHALL be 0 and the last-winner flag SHALL be DM.
REQ-033 Reset asserted during an ACC state SHALL abort that access, with no RVALID produced afterward.
REQ-034 Reset asserted during a DM write ACC cycle SHALL force MEMWRITE to 0 in that cycle.

Configuration
REQ-035 With MEM_ARB_RR_EN defined, a two-way conflict SHALL grant the requester opposite the last winner, so the first conflict after reset goes to IF.
REQ-036 With MEM_ARB_RR_EN defined, the last-winner flag SHALL update on every grant.
REQ-037 With MEM_ARB_RR_EN undefined, fixed DM priority SHALL apply and the last-winner flag SHALL NOT be implemented.

Structure
REQ-038 ADDR_W/DATA_W defaults and the state enum (IDLE=0, IF_ACC=1, DM_ACC=2) SHALL live in the shared package riscblade_pkg.
REQ-039 The combinational winner selection SHALL be the sub-module mem_arb_pick (inputs IF_REQ, DM_REQ and the last-winner flag; output winner); all remaining logic SHALL be in mem_port_arbiter.

Verification
REQ-040 Reset: RST=1 for 2 cycles with both REQs high -> all outputs 0, BUSY=0; release -> DM_GNT in the first cycle after release.
REQ-041 Fetch: IF_REQ=1, IF_ADDR=0x0004, MEM_OUT=0xA123 -> IF_GNT and PC_EN high one cycle after request, IF_RVALID=1 with IF_RDATA=0xA123 the cycle after.
REQ-042 Store: DM_REQ=1, DM_WE=1, DM_ADDR=0x0100, DM_WDATA=0xBEEF -> one cycle with MEMWRITE=1, MEM_ADDR=0x0100, MEM_DATA=0xBEEF, DM_GNT=1; DM_RVALID stays 0.
REQ-043 Conflict: both REQs held -> default build DM_ACC then IF_ACC with no bubble; with MEM_ARB_RR_EN, IF first then DM; 4 alternating grants over 4 cycles.
REQ-044 Abort: RST pulsed during DM_ACC of a load -> DM_RVALID never asserts, state IDLE next cycle.
REQ-045 Same-requester stream: IF_REQ held for 3 fetches -> IF_GNT pattern 1,0,1,0,1 with IDLE between.
